// File: rtl/kbd_cmd_decoder.sv
// PS/2 Set-2 make/break decoder: glyph select, colour/fill and cursor pulses, typematic suppression.
// Define KBD_CMD_DECODER_REPEAT_EN to let every make (including repeats) execute its action.
module kbd_cmd_decoder #(
    parameter int NUM_CHARS   = 4,
    parameter int ADDR_W      = 6,
    parameter int CHAR_STRIDE = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flag,
    input  logic [7:0]        scancode,
    output logic [ADDR_W-1:0] start_address_out,
    output logic              char_enable,
    output logic              r,
    output logic              g,
    output logic              b,
    output logic              f,
    output logic [2:0]        up,
    output logic              seq_err
);

    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    // Digit keys in glyph order 1..9,0
    localparam logic [7:0] DIGIT_CODES [10] = '{
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45
    };

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [8:0]       r_held;
    logic             r_held_valid;

    logic [1:0]        w_state_next;
    logic              w_is_e0;
    logic              w_is_f0;
    logic              w_ext;
    logic              w_brk;
    logic              w_final;
    logic              w_expire;
    logic              w_repeat;
    logic              w_do_make;
    logic [8:0]        w_key;
    logic [9:0]        w_digit_hit;
    logic              w_digit_any;
    logic [ADDR_W-1:0] w_addr_part [10];
    logic [ADDR_W-1:0] w_digit_addr;

    assign w_is_e0  = (scancode == 8'hE0);
    assign w_is_f0  = (scancode == 8'hF0);
    assign w_ext    = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    assign w_brk    = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
    assign w_final  = flag && !w_is_e0 && !w_is_f0;
    assign w_key    = {w_ext, scancode};
    assign w_expire = !flag && (r_state != ST_IDLE) && (r_cnt == CNT_W'(TIMEOUT - 1));

`ifdef KBD_CMD_DECODER_REPEAT_EN
    assign w_repeat = 1'b0;
`else
    assign w_repeat = r_held_valid && (r_held == w_key);
`endif

    assign w_do_make = w_final && !w_brk && !w_repeat;

    // Only digits below NUM_CHARS are live; the others never hit.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_digit
            if (gi < NUM_CHARS) begin : g_on
                assign w_digit_hit[gi] = (scancode == DIGIT_CODES[gi]);
                assign w_addr_part[gi] = w_digit_hit[gi] ? ADDR_W'(gi * CHAR_STRIDE) : '0;
            end else begin : g_off
                assign w_digit_hit[gi] = 1'b0;
                assign w_addr_part[gi] = '0;
            end
        end
    endgenerate

    assign w_digit_any = |w_digit_hit;

    always_comb begin
        w_digit_addr = '0;
        for (int i = 0; i < 10; i++) begin
            w_digit_addr = w_digit_addr | w_addr_part[i];
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flag) begin
            case (r_state)
                ST_IDLE:  w_state_next = w_is_e0 ? ST_EXT : (w_is_f0 ? ST_BRK : ST_IDLE);
                ST_EXT:   w_state_next = w_is_f0 ? ST_EXT_BRK : (w_is_e0 ? ST_EXT : ST_IDLE);
                ST_BRK:   w_state_next = w_is_e0 ? ST_EXT_BRK : (w_is_f0 ? ST_BRK : ST_IDLE);
                default:  w_state_next = (w_is_e0 || w_is_f0) ? ST_EXT_BRK : ST_IDLE;
            endcase
        end else if (w_expire) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_held       <= '0;
            r_held_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (flag || w_expire || (r_state == ST_IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_final) begin
                if (!w_brk) begin
                    r_held       <= w_key;
                    r_held_valid <= 1'b1;
                end else if (r_held == w_key) begin
                    r_held_valid <= 1'b0;
                end
            end
        end
    end

    // Pulses default low every cycle; only an executed make or an expiry raises them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_address_out <= '0;
            char_enable       <= 1'b0;
            r                 <= 1'b0;
            g                 <= 1'b0;
            b                 <= 1'b0;
            f                 <= 1'b0;
            up                <= 3'b000;
            seq_err           <= 1'b0;
        end else begin
            r       <= 1'b0;
            g       <= 1'b0;
            b       <= 1'b0;
            f       <= 1'b0;
            up      <= 3'b000;
            seq_err <= w_expire;
            if (w_do_make) begin
                if (!w_ext) begin
                    if (w_digit_any) begin
                        start_address_out <= w_digit_addr;
                        char_enable       <= 1'b1;
                    end
                    case (scancode)
                        8'h2D:   r <= 1'b1;
                        8'h34:   g <= 1'b1;
                        8'h32:   b <= 1'b1;
                        8'h2B:   f <= 1'b1;
                        8'h76:   char_enable <= 1'b0;
                        default: ;
                    endcase
                end else begin
                    case (scancode)
                        8'h75:   up <= 3'b100;
                        8'h72:   up <= 3'b011;
                        8'h6B:   up <= 3'b001;
                        8'h74:   up <= 3'b010;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
